// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter: requester count,
// FSM state encoding, default hold limit and the rotating-priority pick function.
package mux4_arb_pkg;

  localparam int NUM_REQ          = 4;
  localparam int MAX_HOLD_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First requester at or after ptr, wrapping mod 4. Scanning from the far end
  // lets the nearest requester overwrite later ones without a loop exit.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = idx;
    end
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] idx);
    one_hot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_path.sv
// Shared-output datapath: 4:1 select tree built from three 2:1 muxes,
// forced to zero when no requester owns the output.
module mux4_path #(
  parameter int WIDTH = 1
) (
  input  logic [1:0]       sel,
  input  logic             valid,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] pick;

  assign lo   = sel[0] ? din1 : din0;
  assign hi   = sel[0] ? din3 : din2;
  assign pick = sel[1] ? hi : lo;
  assign dout = valid ? pick : '0;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time, driving a shared
// 4:1 data output from the registered owner index.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic       rel;
  logic [1:0] ptr_next;
  logic [1:0] win_idle;
  logic [1:0] win_rel;

  assign ptr_next = sel_q + 2'd1;
  assign win_idle = pick(req, ptr_q);
  assign win_rel  = pick(req, ptr_next);

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can leave
    // a signal unassigned and infer a latch.
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = win_idle;
          gnt_d   = one_hot(win_idle);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        rel = !req[sel_q] || (cnt_q == HOLD_LAST);
        if (!rel) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          ptr_d = ptr_next;
          if (|req) begin
            // Hand over without an idle bubble; the releasing owner can win
            // again only if nobody else is asking.
            sel_d = win_rel;
            gnt_d = one_hot(win_rel);
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = (state_q == GRANT);

  mux4_path #(
    .WIDTH(WIDTH)
  ) u_path (
    .sel  (sel_q),
    .valid(valid),
    .din0 (din0),
    .din1 (din1),
    .din2 (din2),
    .din3 (din3),
    .dout (dout)
  );

endmodule
